// File: rtl/pio_in_pkg.sv
// Shared constants for the inbound Avalon-MM PIO.
// PIO_IN_SYNC_EN selects a two-flop synchronizer in the input stage; the
// input-stage depth constant below follows the same macro.
package pio_pkg;

    localparam int unsigned PIO_BUS_W  = 32;
    localparam int unsigned PIO_ADDR_W = 2;
    localparam int unsigned PIO_ARM_W  = 2;

    // Register word offsets
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_EDGECAP = 2'd3;

    // Edge type encodings
    localparam int unsigned PIO_EDGE_RISE = 0;
    localparam int unsigned PIO_EDGE_FALL = 1;
    localparam int unsigned PIO_EDGE_ANY  = 2;

    // Number of flops between in_port and data_q (data_q included)
`ifdef PIO_IN_SYNC_EN
    localparam int unsigned PIO_SYNC_DEPTH = 2;
`else
    localparam int unsigned PIO_SYNC_DEPTH = 1;
`endif

endpackage

// File: rtl/pio_in_if.sv
// Avalon-MM slave bus of the inbound PIO, with level interrupt.
interface pio_in_if;

    logic [pio_pkg::PIO_ADDR_W-1:0] address;
    logic                           chipselect;
    logic                           write_n;
    logic [pio_pkg::PIO_BUS_W-1:0]  writedata;
    logic [pio_pkg::PIO_BUS_W-1:0]  readdata;
    logic                           irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/pio_in_sync.sv
// Input stage of the PIO: one register, or a two-flop synchronizer when
// PIO_IN_SYNC_EN is defined. The last flop of the stage is data_q.
module pio_in_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

`ifdef PIO_IN_SYNC_EN
    logic [WIDTH-1:0] meta_q;

    // Two-flop synchronizer for a fully asynchronous input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end
`else
    // Single sampling register for an input already synchronous to clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end
`endif

endmodule

// File: rtl/pio_in.sv
// Avalon-MM input PIO: samples in_port, captures edges per bit into a
// W1C register and raises a masked level interrupt.
// PIO_IN_SYNC_EN adds a two-flop synchronizer ahead of data_q.
module pio_in
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EDGE_TYPE = PIO_EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_in_if.slave          bus,
    input  logic [WIDTH-1:0] in_port
);

    // Detection is held off until data_q and prev_q both carry real samples
    localparam logic [PIO_ARM_W-1:0] ARM_SAT = PIO_ARM_W'(PIO_SYNC_DEPTH + 1);

    logic [WIDTH-1:0]     data_q;
    logic [WIDTH-1:0]     prev_q;
    logic [WIDTH-1:0]     irqmask_q;
    logic [WIDTH-1:0]     edgecap_q;
    logic [PIO_ARM_W-1:0] arm_cnt_q;
    logic [PIO_BUS_W-1:0] readdata_q;

    logic                 wr_c;
    logic                 armed_c;
    logic [WIDTH-1:0]     edge_c;
    logic [WIDTH-1:0]     w1c_c;
    logic [WIDTH-1:0]     edgecap_d;
    logic [PIO_BUS_W-1:0] rdata_c;
    logic                 unused_wdata;

    pio_in_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (data_q)
    );

    assign wr_c    = bus.chipselect && !bus.write_n;
    assign armed_c = (arm_cnt_q == ARM_SAT);

    // Per-bit edge detection of the selected type
    always_comb begin
        edge_c = data_q & ~prev_q;
        if (EDGE_TYPE == PIO_EDGE_FALL) begin
            edge_c = ~data_q & prev_q;
        end else if (EDGE_TYPE == PIO_EDGE_ANY) begin
            edge_c = data_q ^ prev_q;
        end
    end

    // Edge capture: W1C clear, then a new edge sets (set wins a collision)
    always_comb begin
        w1c_c = '0;
        if (wr_c && (bus.address == PIO_ADDR_EDGECAP)) begin
            w1c_c = bus.writedata[WIDTH-1:0];
        end
        edgecap_d = edgecap_q & ~w1c_c;
        if (armed_c) begin
            edgecap_d = edgecap_d | edge_c;
        end
    end

    // Read address mux, zero-extended to the bus width
    always_comb begin
        rdata_c = '0;
        case (bus.address)
            PIO_ADDR_DATA:    rdata_c = PIO_BUS_W'(data_q);
            PIO_ADDR_IRQMASK: rdata_c = PIO_BUS_W'(irqmask_q);
            PIO_ADDR_EDGECAP: rdata_c = PIO_BUS_W'(edgecap_q);
            default:          rdata_c = '0;
        endcase
    end

    // State registers: history, mask, captures, arming counter, read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            arm_cnt_q  <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= data_q;
            edgecap_q  <= edgecap_d;
            readdata_q <= rdata_c;
            if (!armed_c) begin
                arm_cnt_q <= arm_cnt_q + PIO_ARM_W'(1);
            end
            if (wr_c && (bus.address == PIO_ADDR_IRQMASK)) begin
                irqmask_q <= bus.writedata[WIDTH-1:0];
            end
        end
    end

    assign bus.readdata = readdata_q;
    // Decoded from flops only, so it cannot glitch across a cycle boundary
    assign bus.irq      = |(edgecap_q & irqmask_q);

    // Upper write-data bits are not used when WIDTH < 32
    assign unused_wdata = &{1'b0, bus.writedata};

endmodule

// File: tb/tb_pio_in.sv
// Scoreboard bench for pio_in: three instances (rise/fall/any) share one
// stimulus stream; a cycle-level reference model predicts read data and irq.
module tb_pio_in;

    localparam int W = 8;
`ifdef PIO_IN_SYNC_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef logic [2:0][31:0] rd3_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic [1:0]   t_addr;
    logic         t_cs;
    logic         t_wn;
    logic [31:0]  t_wd;

    pio_in_if bus_r ();
    pio_in_if bus_f ();
    pio_in_if bus_a ();

    assign bus_r.address = t_addr;  assign bus_r.chipselect = t_cs;
    assign bus_r.write_n = t_wn;    assign bus_r.writedata  = t_wd;
    assign bus_f.address = t_addr;  assign bus_f.chipselect = t_cs;
    assign bus_f.write_n = t_wn;    assign bus_f.writedata  = t_wd;
    assign bus_a.address = t_addr;  assign bus_a.chipselect = t_cs;
    assign bus_a.write_n = t_wn;    assign bus_a.writedata  = t_wd;

    pio_in #(.WIDTH(W), .EDGE_TYPE(0)) dut_r (.clk(clk), .reset_n(reset_n), .bus(bus_r), .in_port(in_port));
    pio_in #(.WIDTH(W), .EDGE_TYPE(1)) dut_f (.clk(clk), .reset_n(reset_n), .bus(bus_f), .in_port(in_port));
    pio_in #(.WIDTH(W), .EDGE_TYPE(2)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_port));

    logic [31:0] rd_act [3];
    logic        irq_act [3];
    assign rd_act[0] = bus_r.readdata;  assign irq_act[0] = bus_r.irq;
    assign rd_act[1] = bus_f.readdata;  assign irq_act[1] = bus_f.irq;
    assign rd_act[2] = bus_a.readdata;  assign irq_act[2] = bus_a.irq;

    string nm [3] = '{"rise", "fall", "any"};

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int           n;
    logic [W-1:0] hist [$];
    logic [W-1:0] mask_m;
    logic [W-1:0] cap_m [3];
    logic         irq_m [3];
    rd3_t         exp_q [$];

    task automatic chk(string what, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", what, act, exp, $time);
        end
    endtask

    // Sampled input value visible at data_q after k clock edges since reset
    function automatic logic [W-1:0] data_after(int k);
        if (k < DEPTH) return '0;
        return hist[k-DEPTH];
    endfunction

    function automatic logic [W-1:0] detect(int t, logic [W-1:0] c, logic [W-1:0] p);
        case (t)
            0:       return c & ~p;
            1:       return ~c & p;
            default: return c ^ p;
        endcase
    endfunction

    task automatic model_clear();
        n      = 0;
        hist.delete();
        exp_q.delete();
        mask_m = '0;
        for (int t = 0; t < 3; t++) begin
            cap_m[t] = '0;
            irq_m[t] = 1'b0;
        end
    endtask

    // Reference model: one update per clock edge, cleared by reset
    initial begin : model
        logic [W-1:0] cur, prv, w1c;
        logic         armed;
        rd3_t         r;
        model_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_clear();
            end else begin
                cur   = data_after(n);
                prv   = data_after(n - 1);
                armed = (n >= DEPTH + 1);
                if (t_cs && t_wn) begin
                    for (int t = 0; t < 3; t++) begin
                        case (t_addr)
                            2'd0:    r[t] = 32'(cur);
                            2'd2:    r[t] = 32'(mask_m);
                            2'd3:    r[t] = 32'(cap_m[t]);
                            default: r[t] = 32'd0;
                        endcase
                    end
                    exp_q.push_back(r);
                end
                w1c = (t_cs && !t_wn && t_addr == 2'd3) ? t_wd[W-1:0] : '0;
                for (int t = 0; t < 3; t++) begin
                    cap_m[t] = (cap_m[t] & ~w1c) | (armed ? detect(t, cur, prv) : '0);
                end
                if (t_cs && !t_wn && t_addr == 2'd2) mask_m = t_wd[W-1:0];
                hist.push_back(in_port);
                n++;
                for (int t = 0; t < 3; t++) irq_m[t] = |(cap_m[t] & mask_m);
            end
        end
    end

    // Monitor: read data one cycle after each read, irq every cycle
    initial begin : monitor
        rd3_t r;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                for (int t = 0; t < 3; t++) chk({"readdata_", nm[t]}, rd_act[t], r[t]);
            end
            for (int t = 0; t < 3; t++) chk({"irq_", nm[t]}, 32'(irq_act[t]), 32'(irq_m[t]));
        end
    end

    task automatic step(logic cs, logic wn, logic [1:0] a, logic [31:0] wd, logic [W-1:0] inp);
        @(negedge clk);
        t_cs = cs; t_wn = wn; t_addr = a; t_wd = wd; in_port = inp;
    endtask

    task automatic idle(int k);
        repeat (k) step(1'b0, 1'b1, 2'd0, 32'd0, in_port);
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        step(1'b1, 1'b0, a, d, in_port);
    endtask

    task automatic rd(logic [1:0] a);
        step(1'b1, 1'b1, a, 32'd0, in_port);
    endtask

    task automatic setin(logic [W-1:0] v);
        step(1'b0, 1'b1, 2'd0, 32'd0, v);
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear at once
    task automatic async_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        for (int t = 0; t < 3; t++) begin
            chk({"rst_readdata_", nm[t]}, rd_act[t], 32'd0);
            chk({"rst_irq_", nm[t]}, 32'(irq_act[t]), 32'd0);
        end
        t_cs = 1'b0; t_wn = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : stim
        int op;
        reset_n = 1'b0;
        t_cs = 1'b0; t_wn = 1'b1; t_addr = 2'd0; t_wd = 32'd0;
        in_port = 8'hFF;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Input high through reset: no edge after arming, DATA = FF
        idle(DEPTH + 2);
        rd(2'd0); rd(2'd3); rd(2'd2); idle(1);

        // Rising edge on bit0 with mask bit0, then W1C
        wr(2'd2, 32'h1);
        setin(8'hFE); idle(4);
        setin(8'hFF); idle(DEPTH + 2);
        rd(2'd3); wr(2'd3, 32'h1); rd(2'd3); idle(1);

        // W1C on bit2 in the same cycle a new edge on bit2 is detected
        setin(8'hFB); idle(4);
        setin(8'hFF); idle(4);
        setin(8'hFB); idle(4);
        setin(8'hFF); idle(DEPTH - 1);
        wr(2'd3, 32'h4); rd(2'd3); idle(1);

        // Bit5 toggle with mask 0, then unmask
        wr(2'd2, 32'h0); wr(2'd3, 32'hFF);
        setin(8'hDF); idle(3);
        setin(8'hFF); idle(DEPTH + 2);
        rd(2'd3); wr(2'd2, 32'h20); rd(2'd2); idle(1);

        // Writes to DATA and reserved word are ignored; mask reads zero-extended
        wr(2'd0, 32'hDEAD_BEEF); wr(2'd1, 32'hDEAD_BEEF);
        rd(2'd0); rd(2'd1);
        wr(2'd2, 32'hFFFF_FFA5); rd(2'd2); idle(1);

        // Capture 0F with irq high, then asynchronous reset and re-arm
        wr(2'd3, 32'hFF); wr(2'd2, 32'h0F);
        setin(8'hF0); idle(3);
        setin(8'hFF); idle(DEPTH + 2);
        rd(2'd3);
        async_reset();
        idle(DEPTH + 3);
        rd(2'd3); rd(2'd2); rd(2'd0); idle(1);

        // Randomized traffic and input activity
        for (int i = 0; i < 800; i++) begin
            logic [W-1:0] nx;
            nx = in_port;
            if ($urandom_range(0, 2) == 0) nx = in_port ^ W'($urandom);
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2: step(1'b1, 1'b1, 2'($urandom_range(0, 3)), 32'd0, nx);
                3:       step(1'b1, 1'b0, 2'd2, $urandom, nx);
                4:       step(1'b1, 1'b0, 2'd3, $urandom, nx);
                5:       step(1'b1, 1'b0, 2'($urandom_range(0, 1)), $urandom, nx);
                default: step(1'b0, 1'b1, 2'd0, 32'd0, nx);
            endcase
            if (i == 400) async_reset();
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pio_in.md
# pio_in

Avalon-MM slave input PIO: samples an external `WIDTH`-bit input port, captures selected edges per bit, and raises a level interrupt toward the Nios II/Avalon interconnect. It is the inbound counterpart of the existing output PIO on the same system bus: same 2-bit register address space and 32-bit data bus. It adds registered read data and per-bit edge capture with an interrupt mask.

## Interface
- `WIDTH`, 8: input port width, 1..32.
- `EDGE_TYPE`, 0: captured edge type; 0 = rising, 1 = falling, 2 = any.

- `clk`  in  1  system clock, single domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `in_port`  in  WIDTH  external input pins; may be asynchronous when `PIO_IN_SYNC_EN` is defined.
- `readdata`  out  32  registered read data; upper `32-WIDTH` bits are always 0.
- `irq`  out  1  level interrupt, active high.

## Operation
- Register map:
  - addr 0 DATA (RO): current sampled input `data_q`.
  - addr 1: reads 0; writes ignored.
  - addr 2 IRQMASK (RW): per-bit interrupt enable.
  - addr 3 EDGECAP (R/W1C): captured edges.
- Write access: `chipselect && !write_n`. Writes to addr 0/1 are ignored. IRQMASK loads `writedata[WIDTH-1:0]`. EDGECAP clears each bit whose `writedata` bit is 1.
- Sampling pipeline: `in_port` -> input stage (see Configuration) -> `data_q` -> `prev_q`.
- Edge detect per bit:
  - rising = `data_q & ~prev_q`
  - falling = `~data_q & prev_q`
  - any = `data_q ^ prev_q`
- Arming: a 2-bit `arm_cnt` counts up from 0 after reset and saturates. Edge detection is enabled only when `arm_cnt` has saturated (pipeline depth + 1 cycles). This prevents false edges from reset values.
- Capture: `edgecap[i]` sets on a detected edge and holds until cleared.
- Set-vs-clear collision: a W1C write on bit i in the same cycle as a new edge on bit i leaves the bit set (set wins).
- `irq = |(edgecap & irqmask)`. It is decoded from flops only and is glitch-free at cycle boundaries.
- Reset values: `data_q`, `prev_q`, sync stages, `irqmask`, `edgecap`, `arm_cnt`, `readdata` all 0; `irq` 0.
- Reset asserted mid-operation clears all state immediately (asynchronous). The arming sequence restarts on deassertion.

## Timing
- `readdata` is registered every cycle from the address mux, regardless of `chipselect`. Avalon read latency = 1; wait states = 0.
- A write takes effect at the clock edge where it is presented. A read in the next cycle returns the new value.
- `in_port` -> `data_q`: 2 cycles with sync, 1 cycle without.
- `in_port` edge -> `edgecap`/`irq` high: 3 cycles with sync, 2 without.
- Input pulses shorter than one `clk` period may be missed. This is by design.

## Configuration
- `PIO_IN_SYNC_EN` defined: a two-flop synchronizer precedes `data_q`, so the input stage is 2 flops and latencies are as listed with sync. `in_port` may be fully asynchronous.
- `PIO_IN_SYNC_EN` undefined: a single register precedes `data_q`. `in_port` must be synchronous to `clk`. `arm_cnt` saturation threshold drops by one accordingly.

## Structure
- Package `pio_pkg`:
  - register offsets: `PIO_ADDR_DATA`=0, `PIO_ADDR_IRQMASK`=2, `PIO_ADDR_EDGECAP`=3
  - edge encodings: `PIO_EDGE_RISE`=0, `PIO_EDGE_FALL`=1, `PIO_EDGE_ANY`=2
- Sub-module `pio_in_sync`: parameterised-width 1- or 2-stage input register, with reset to 0. It contains the `PIO_IN_SYNC_EN` selection.

## Test plan
- Reset with `in_port`=8'hFF held -> after arming, DATA reads 8'hFF, EDGECAP reads 0, `irq`=0.
- `EDGE_TYPE`=0, IRQMASK=8'h01, drive `in_port` bit0 0->1 -> EDGECAP=8'h01 and `irq`=1 exactly 3 cycles later (sync on). Write 32'h1 to addr 3 -> EDGECAP=0, `irq`=0 next cycle.
- W1C of bit2 in the same cycle bit2 captures a new edge -> EDGECAP bit2 stays 1.
- `EDGE_TYPE`=2, toggle bit5 1->0->1 with IRQMASK=0 -> EDGECAP=8'h20, `irq` stays 0. Then write IRQMASK=8'h20 -> `irq`=1 next cycle.
- Write 32'hDEAD_BEEF to addr 0 and addr 1 -> DATA is unchanged and addr 1 reads 0. Read of addr 2 returns 32'h0000_00XX, with upper bits 0.
- Assert `reset_n` low with EDGECAP=8'h0F and `irq`=1 -> `irq` and all registers are 0 immediately, and no edge is captured during re-arming.
